// File: rtl/num_ascii_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : num_ascii_pkg
//  Purpose  : Shared types and constants for the number-to-ASCII UART sender:
//             FSM state encoding, terminator modes, ASCII byte values and the
//             digit-to-character mapping.
//  Revision : 1.0 - initial release
// ============================================================================
package num_ascii_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CONV   = 3'd1,
        SEND   = 3'd2,
        WAIT_H = 3'd3,
        WAIT_L = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [1:0] TAIL_NONE      = 2'd0;
    localparam logic [1:0] TAIL_CHAR      = 2'd1;
    localparam logic [1:0] TAIL_CRLF      = 2'd2;
    localparam logic [1:0] TAIL_CHAR_CRLF = 2'd3;

    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_A     = 8'h41;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_X     = 8'h78;

    // 0-9 -> '0'..'9', 10-15 -> 'A'..'F'
    function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
        if (d < 4'd10) begin
            return ASC_0 + {4'd0, d};
        end
        return ASC_A + {4'd0, d - 4'd10};
    endfunction

endpackage
`default_nettype wire

// File: rtl/num_ascii_div10.sv
`default_nettype none
// ============================================================================
//  Module   : num_ascii_div10
//  Purpose  : Serial restoring divide-by-10. One quotient bit per cycle, so a
//             division takes DATA_W cycles after the start pulse. done pulses
//             for one cycle when quotient/remainder are valid; they then hold
//             until the next start.
//  Revision : 1.0 - initial release
// ============================================================================
module num_ascii_div10 #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    output logic [DATA_W-1:0] quotient,
    output logic [3:0]        remainder,
    output logic              done
);

    localparam int CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] shreg;
    logic [3:0]        rem;
    logic [CW-1:0]     bits_left;
    logic              running;
    logic [4:0]        trial;
    logic              ge;
    logic [3:0]        rem_nxt;

    // Restoring step: bring in the next dividend bit and subtract 10 if it fits
    always_comb begin
        trial   = {rem, shreg[DATA_W-1]};
        ge      = (trial >= 5'd10);
        rem_nxt = ge ? 4'(trial - 5'd10) : trial[3:0];
    end

    // Shift register holds the dividend and fills with quotient bits from the LSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            rem       <= '0;
            bits_left <= '0;
            running   <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                shreg     <= dividend;
                rem       <= '0;
                bits_left <= CW'(DATA_W);
                running   <= 1'b1;
            end else if (running) begin
                shreg     <= {shreg[DATA_W-2:0], ge};
                rem       <= rem_nxt;
                bits_left <= bits_left - CW'(1);
                if (bits_left == CW'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign quotient  = shreg;
    assign remainder = rem;

endmodule
`default_nettype wire

// File: rtl/num_ascii_tx.sv
`default_nettype none
// ============================================================================
//  Module   : num_ascii_tx
//  Purpose  : Converts a DATA_W-bit value to decimal or uppercase hex text
//             (optional '-', zero padding, selectable terminator) and feeds it
//             byte by byte to a shared uart_tx using its start/busy handshake.
//  Options  : NUM_ASCII_HEX_PREFIX_EN - when defined, hex output is preceded
//             by "0x"; padding still counts digits only.
//  Revision : 1.0 - initial release
// ============================================================================
module num_ascii_tx
    import num_ascii_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int MAX_DIGITS = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] value,
    input  logic              is_signed,
    input  logic              hex_mode,
    input  logic [3:0]        pad_width,
    input  logic [1:0]        tail_mode,
    input  logic [7:0]        tail_char,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = ($clog2(MAX_DIGITS + 1) > 4) ? $clog2(MAX_DIGITS + 1) : 4;
    localparam int IDX_W = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

    // Byte kinds of a frame, in transmission order
    localparam logic [3:0] K_NONE  = 4'd0;
    localparam logic [3:0] K_SIGN  = 4'd1;
`ifdef NUM_ASCII_HEX_PREFIX_EN
    localparam logic [3:0] K_PFX0  = 4'd2;
    localparam logic [3:0] K_PFXX  = 4'd3;
`endif
    localparam logic [3:0] K_DIGIT = 4'd4;
    localparam logic [3:0] K_TCHAR = 4'd5;
    localparam logic [3:0] K_CR    = 4'd6;
    localparam logic [3:0] K_LF    = 4'd7;
    localparam logic [3:0] K_END   = 4'd8;

    state_t            state;
    state_t            state_nxt;

    // Latched request
    logic [DATA_W-1:0] work;
    logic              neg_r;
    logic              hex_r;
    logic [CNT_W-1:0]  pad_r;
    logic [1:0]        tail_r;
    logic [7:0]        tchar_r;

    // Digit buffer, LSB digit at index 0
    logic [3:0]        dbuf [MAX_DIGITS];
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        kind;
    logic [IDX_W-1:0]  dig_idx;

    // Divider interface
    logic              div_go;
    logic              div_done;
    logic [DATA_W-1:0] div_q;
    logic [3:0]        div_rem;

    // Combinational helpers
    logic              accept;
    logic              neg_in;
    logic [DATA_W-1:0] mag_in;
    logic [CNT_W-1:0]  pad_in;
    logic              conv_step;
    logic [3:0]        conv_digit;
    logic [DATA_W-1:0] conv_rest;
    logic [CNT_W-1:0]  cnt_inc;
    logic              conv_more;
    logic              use_char;
    logic              use_crlf;
    logic [3:0]        adv_kind;
    logic [IDX_W-1:0]  adv_idx;
    logic [7:0]        cur_byte;
    logic              strobe;

    num_ascii_div10 #(
        .DATA_W (DATA_W)
    ) u_div10 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_go),
        .dividend  (work),
        .quotient  (div_q),
        .remainder (div_rem),
        .done      (div_done)
    );

    // Whether a byte kind appears in the current frame
    function automatic logic kind_used(input logic [3:0] k);
        logic app;
        case (k)
            K_SIGN:       app = neg_r;
`ifdef NUM_ASCII_HEX_PREFIX_EN
            K_PFX0,
            K_PFXX:       app = hex_r;
`endif
            K_DIGIT:      app = 1'b1;
            K_TCHAR:      app = use_char;
            K_CR, K_LF:   app = use_crlf;
            K_END:        app = 1'b1;
            default:      app = 1'b0;
        endcase
        return app;
    endfunction

    // First byte kind after cur that belongs to the frame
    function automatic logic [3:0] next_kind(input logic [3:0] cur);
        logic [3:0] res;
        res = K_END;
        for (int i = 8; i >= 1; i--) begin
            if ((4'(i) > cur) && kind_used(4'(i))) begin
                res = 4'(i);
            end
        end
        return res;
    endfunction

    // Request decode: sign handling and effective pad width
    always_comb begin
        accept = (state == IDLE) && start;
        neg_in = is_signed && !hex_mode && value[DATA_W-1];
        mag_in = neg_in ? ((~value) + DATA_W'(1)) : value;
        if (pad_width == 4'd0) begin
            pad_in = CNT_W'(1);
        end else if (CNT_W'(pad_width) > MAX_CNT) begin
            pad_in = MAX_CNT;
        end else begin
            pad_in = CNT_W'(pad_width);
        end
    end

    // Terminator decode
    always_comb begin
        use_char = 1'b0;
        use_crlf = 1'b0;
        case (tail_r)
            TAIL_NONE:      ;
            TAIL_CHAR:      use_char = 1'b1;
            TAIL_CRLF:      use_crlf = 1'b1;
            TAIL_CHAR_CRLF: begin
                use_char = 1'b1;
                use_crlf = 1'b1;
            end
        endcase
    end

    // One conversion step: a nibble per cycle in hex, a finished division in decimal
    always_comb begin
        conv_step  = (state == CONV) && (hex_r || div_done);
        conv_digit = hex_r ? work[3:0] : div_rem;
        conv_rest  = hex_r ? (work >> 4) : div_q;
        cnt_inc    = cnt + CNT_W'(1);
        conv_more  = ((conv_rest != '0) || (cnt_inc < pad_r)) && (cnt_inc < MAX_CNT);
    end

    // Byte selection and advance to the following byte after each handshake
    always_comb begin
        if ((kind == K_DIGIT) && (dig_idx != '0)) begin
            adv_kind = K_DIGIT;
            adv_idx  = dig_idx - IDX_W'(1);
        end else begin
            adv_kind = next_kind(kind);
            adv_idx  = dig_idx;
        end
        case (kind)
            K_SIGN:  cur_byte = ASC_MINUS;
`ifdef NUM_ASCII_HEX_PREFIX_EN
            K_PFX0:  cur_byte = ASC_0;
            K_PFXX:  cur_byte = ASC_X;
`endif
            K_DIGIT: cur_byte = digit_to_ascii(dbuf[dig_idx]);
            K_TCHAR: cur_byte = tchar_r;
            K_CR:    cur_byte = ASC_CR;
            K_LF:    cur_byte = ASC_LF;
            default: cur_byte = 8'h00;
        endcase
    end

    // Request latch, digit buffer fill and frame position tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work    <= '0;
            neg_r   <= 1'b0;
            hex_r   <= 1'b0;
            pad_r   <= '0;
            tail_r  <= '0;
            tchar_r <= '0;
            cnt     <= '0;
            kind    <= K_NONE;
            dig_idx <= '0;
            div_go  <= 1'b0;
            for (int i = 0; i < MAX_DIGITS; i++) begin
                dbuf[i] <= '0;
            end
        end else begin
            div_go <= 1'b0;
            if (accept) begin
                work    <= mag_in;
                neg_r   <= neg_in;
                hex_r   <= hex_mode;
                pad_r   <= pad_in;
                tail_r  <= tail_mode;
                tchar_r <= tail_char;
                cnt     <= '0;
                kind    <= K_NONE;
                dig_idx <= '0;
                div_go  <= !hex_mode;
            end
            if (conv_step) begin
                dbuf[IDX_W'(cnt)] <= conv_digit;
                cnt               <= cnt_inc;
                work              <= conv_rest;
                if (conv_more) begin
                    div_go <= !hex_r;
                end else begin
                    // cnt is the index of the digit just stored: the most significant one
                    kind    <= next_kind(K_NONE);
                    dig_idx <= IDX_W'(cnt);
                end
            end
            if ((state == WAIT_L) && !tx_busy) begin
                kind    <= adv_kind;
                dig_idx <= adv_idx;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start) state_nxt = CONV;
            CONV:   if (conv_step && !conv_more) state_nxt = SEND;
            SEND:   if (!tx_busy) state_nxt = WAIT_H;
            WAIT_H: if (tx_busy) state_nxt = WAIT_L;
            WAIT_L: if (!tx_busy) state_nxt = (adv_kind == K_END) ? DONE : SEND;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy   = (state != IDLE) && (state != DONE);
        done   = (state == DONE);
        strobe = (state == SEND) && !tx_busy;
    end

    // Byte strobe register; tx_data only changes together with a strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            tx_start <= strobe;
            if (strobe) begin
                tx_data <= cur_byte;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_num_ascii_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_num_ascii_tx
//  Purpose  : Self-checking bench for num_ascii_tx with a uart_tx busy model
//             and a scoreboard of expected bytes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_num_ascii_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] value;
    logic        is_signed;
    logic        hex_mode;
    logic [3:0]  pad_width;
    logic [1:0]  tail_mode;
    logic [7:0]  tail_char;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic        done;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_b;
    int          dly_max = 0;
    bit          prev_start = 1'b0;

    always #5 clk = ~clk;

    num_ascii_tx #(
        .DATA_W     (16),
        .MAX_DIGITS (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .value     (value),
        .is_signed (is_signed),
        .hex_mode  (hex_mode),
        .pad_width (pad_width),
        .tail_mode (tail_mode),
        .tail_char (tail_char),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .busy      (busy),
        .done      (done)
    );

    // uart_tx model: busy rises 0..dly_max cycles after a strobe, stays 1..4 cycles
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                repeat ($urandom_range(0, dly_max)) @(negedge clk);
                tx_busy = 1'b1;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    // Scoreboard: every strobe must match the next expected byte
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                checks++;
                if (prev_start) begin
                    errors++;
                    $display("FAIL strobe_gap: tx_start high in consecutive cycles (data %02h)", tx_data);
                end
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got %02h, expected no byte", tx_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (tx_data !== exp_b) begin
                        errors++;
                        $display("FAIL byte: got %02h, expected %02h", tx_data, exp_b);
                    end
                end
            end
            prev_start = (tx_start === 1'b1);
        end
    end

    // Reference model of a frame
    task automatic push_model(input logic [15:0] v, input bit sg, input bit hx,
                              input logic [3:0] pw, input logic [1:0] tm, input logic [7:0] tc);
        int unsigned mag;
        int unsigned base;
        int          pe;
        bit          neg;
        int          digs[$];
        neg  = sg && !hx && v[15];
        mag  = neg ? (32'd65536 - {16'd0, v}) : {16'd0, v};
        base = hx ? 16 : 10;
        pe   = (pw == 4'd0) ? 1 : ((pw > 4'd5) ? 5 : int'(pw));
        do begin
            digs.push_back(int'(mag % base));
            mag = mag / base;
        end while (mag != 0 || digs.size() < pe);
        if (neg) exp_q.push_back(8'h2D);
`ifdef NUM_ASCII_HEX_PREFIX_EN
        if (hx) begin
            exp_q.push_back(8'h30);
            exp_q.push_back(8'h78);
        end
`endif
        for (int i = digs.size() - 1; i >= 0; i--) begin
            exp_q.push_back((digs[i] < 10) ? 8'(8'h30 + digs[i]) : 8'(8'h37 + digs[i]));
        end
        if (tm == 2'd1 || tm == 2'd3) exp_q.push_back(tc);
        if (tm[1]) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    // Pulse start for one cycle, then scramble the inputs to prove they were latched
    task automatic issue(input logic [15:0] v, input bit sg, input bit hx,
                         input logic [3:0] pw, input logic [1:0] tm, input logic [7:0] tc);
        @(negedge clk);
        value = v; is_signed = sg; hex_mode = hx;
        pad_width = pw; tail_mode = tm; tail_char = tc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        value = ~v; is_signed = ~sg; hex_mode = ~hx;
        pad_width = ~pw; tail_mode = ~tm; tail_char = ~tc;
    endtask

    // Wait for done with a cycle budget; busy must stay high until the done cycle
    task automatic wait_done(input int limit, output bit got, output bit busy_ok);
        got = 1'b0;
        busy_ok = 1'b1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; value = '0; is_signed = 1'b0; hex_mode = 1'b0;
        pad_width = '0; tail_mode = '0; tail_char = '0;
        repeat (3) @(negedge clk);
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b, expected 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %02h, expected 00", tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", done); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_dec_zero();
        bit got, bok;
        dly_max = 2;
        exp_q.push_back(8'h30);
        issue(16'd0, 1'b0, 1'b0, 4'd0, 2'd0, 8'h00);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy_start: got %b, expected 1", busy); end
        wait_done(2000, got, bok);
        checks++; if (!got) begin errors++; $display("FAIL zero_done: got no done, expected done"); end
        checks++; if (!bok) begin errors++; $display("FAIL zero_busy: got busy gap, expected busy until done"); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL zero_left: got %0d bytes unsent, expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_dec_signed();
        bit got, bok;
        logic [7:0] e[8] = '{8'h2D, 8'h33, 8'h32, 8'h37, 8'h36, 8'h38, 8'h0D, 8'h0A};
        foreach (e[i]) exp_q.push_back(e[i]);
        issue(16'h8000, 1'b1, 1'b0, 4'd0, 2'd2, 8'h00);
        wait_done(3000, got, bok);
        checks++; if (!got) begin errors++; $display("FAIL signed_done: got no done, expected done"); end
        checks++; if (!bok) begin errors++; $display("FAIL signed_busy: got busy gap, expected busy until done"); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL signed_left: got %0d bytes unsent, expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_dec_pad();
        bit got, bok;
        logic [7:0] e[6] = '{8'h30, 8'h30, 8'h30, 8'h34, 8'h32, 8'h2C};
        foreach (e[i]) exp_q.push_back(e[i]);
        issue(16'd42, 1'b0, 1'b0, 4'd5, 2'd1, 8'h2C);
        wait_done(3000, got, bok);
        checks++; if (!got) begin errors++; $display("FAIL pad_done: got no done, expected done"); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL pad_left: got %0d bytes unsent, expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_hex();
        bit got, bok;
        logic [7:0] e[7] = '{8'h42, 8'h45, 8'h45, 8'h46, 8'h3B, 8'h0D, 8'h0A};
`ifdef NUM_ASCII_HEX_PREFIX_EN
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h78);
`endif
        foreach (e[i]) exp_q.push_back(e[i]);
        issue(16'hBEEF, 1'b1, 1'b1, 4'd0, 2'd3, 8'h3B);
        wait_done(3000, got, bok);
        checks++; if (!got) begin errors++; $display("FAIL hex_done: got no done, expected done"); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL hex_left: got %0d bytes unsent, expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_back_to_back();
        bit got, bok;
        logic [15:0] v;
        bit sg, hx;
        logic [3:0] pw;
        logic [1:0] tm;
        logic [7:0] tc;
        dly_max = 20;
        for (int f = 0; f < 8; f++) begin
            v  = 16'($urandom);
            sg = 1'($urandom);
            hx = 1'($urandom);
            pw = 4'($urandom_range(0, 15));
            tm = 2'($urandom);
            tc = 8'($urandom_range(33, 126));
            push_model(v, sg, hx, pw, tm, tc);
            issue(v, sg, hx, pw, tm, tc);
            // A second request while busy must be dropped
            @(negedge clk);
            value = 16'h1111; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b, expected 1 (frame %0d)", busy, f); end
            wait_done(4000, got, bok);
            checks++; if (!got) begin errors++; $display("FAIL b2b_done: got no done, expected done (frame %0d)", f); end
            checks++; if (!bok) begin errors++; $display("FAIL b2b_busy_span: got busy gap, expected busy until done (frame %0d)", f); end
            checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_left: got %0d bytes unsent, expected 0 (frame %0d)", exp_q.size(), f); exp_q.delete(); end
        end
        // Nothing may follow the dropped request
        repeat (40) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy %b, expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        bit got, bok, seen_done;
        int n;
        dly_max = 3;
        push_model(16'd12345, 1'b0, 1'b0, 4'd0, 2'd0, 8'h00);
        issue(16'd12345, 1'b0, 1'b0, 4'd0, 2'd0, 8'h00);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (tx_start === 1'b1) n++;
            if (n == 3) break;
        end
        checks++; if (n != 3) begin errors++; $display("FAIL mid_third_byte: got %0d strobes, expected 3", n); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL mid_tx_start: got %b, expected 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL mid_tx_data: got %02h, expected 00", tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b, expected 0", busy); end
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        checks++; if (seen_done) begin errors++; $display("FAIL mid_no_done: got done after abort, expected none"); end
        push_model(16'd12345, 1'b0, 1'b0, 4'd0, 2'd2, 8'h00);
        issue(16'd12345, 1'b0, 1'b0, 4'd0, 2'd2, 8'h00);
        wait_done(3000, got, bok);
        checks++; if (!got) begin errors++; $display("FAIL mid_restart_done: got no done, expected done"); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mid_restart_left: got %0d bytes unsent, expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    initial begin
        test_reset();
        test_dec_zero();
        test_dec_signed();
        test_dec_pad();
        test_hex();
        test_back_to_back();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
